// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind a UART receiver: captures each held byte once, acknowledges it
// with a one-cycle RxEnable pulse, and presents the head entry first-word fall-through.
module uart_rx_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [7:0]            RxData,
    input  logic                  RxReady,
    input  logic                  RxError,
    output logic                  RxEnable,
    input  logic                  ReadEnable,
    output logic [7:0]            DataOut,
    output logic                  DataValid,
    output logic                  Full,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Overflow,
    output logic                  FrameError,
    input  logic                  ClearErrors
);

    typedef enum logic {
        IDLE    = 1'b0,
        RELEASE = 1'b1
    } state_t;

    state_t                 state, state_next;
    logic [7:0]             mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]    count;
    logic                   capture, do_write, do_pop, rx_enable_next;

    assign DataValid = (count != '0);
    assign Full      = (count == (ADDR_WIDTH+1)'(DEPTH));
    assign Count     = count;
    assign DataOut   = mem[rd_ptr];

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign do_pop   = ReadEnable && DataValid;
    assign do_write = capture && (!Full || do_pop);

    always_comb begin
        state_next     = state;
        capture        = 1'b0;
        rx_enable_next = 1'b0;
        case (state)
            IDLE: begin
                if (RxReady && !RxError) begin
                    capture        = 1'b1;
                    rx_enable_next = 1'b1;
                    state_next     = RELEASE;
                end
            end
            RELEASE: begin
                if (!RxReady)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            RxEnable <= 1'b0;
        end else begin
            state    <= state_next;
            RxEnable <= rx_enable_next;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 8'h00;
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= RxData;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_write && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_write)
                count <= count - 1'b1;
        end
    end

    // Set events take priority over ClearErrors.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Overflow   <= 1'b0;
            FrameError <= 1'b0;
        end else begin
            if (capture && !do_write)
                Overflow <= 1'b1;
            else if (ClearErrors)
                Overflow <= 1'b0;
            if (RxError)
                FrameError <= 1'b1;
            else if (ClearErrors)
                FrameError <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16).
module tb_uart_rx_fifo;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] RxData = 8'h00;
    logic       RxReady = 1'b0;
    logic       RxError = 1'b0;
    logic       RxEnable;
    logic       ReadEnable = 1'b0;
    logic [7:0] DataOut;
    logic       DataValid;
    logic       Full;
    logic [4:0] Count;
    logic       Overflow;
    logic       FrameError;
    logic       ClearErrors = 1'b0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int p0;
    logic [7:0] model_q[$];
    logic [7:0] exp_b;

    uart_rx_fifo #(.DEPTH(16)) dut (
        .Clk(Clk), .Reset(Reset), .RxData(RxData), .RxReady(RxReady),
        .RxError(RxError), .RxEnable(RxEnable), .ReadEnable(ReadEnable),
        .DataOut(DataOut), .DataValid(DataValid), .Full(Full), .Count(Count),
        .Overflow(Overflow), .FrameError(FrameError), .ClearErrors(ClearErrors)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (RxEnable) pulses++;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0; RxReady = 0; RxError = 0; ReadEnable = 0; ClearErrors = 0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge Clk);
        RxData = b; RxReady = 1'b1;
        @(negedge Clk);
        RxReady = 1'b0;
        @(negedge Clk);
    endtask

    task automatic pop_byte(input string tag, input logic [7:0] exp);
        @(negedge Clk);
        check_val(tag, {31'd0, DataValid}, 32'd1);
        check_val(tag, {24'd0, DataOut}, {24'd0, exp});
        ReadEnable = 1'b1;
        @(negedge Clk);
        ReadEnable = 1'b0;
    endtask

    initial begin
        do_reset();
        @(negedge Clk);
        check_val("rst_count", {27'd0, Count}, 0);
        check_val("rst_valid", {31'd0, DataValid}, 0);
        check_val("rst_full", {31'd0, Full}, 0);
        check_val("rst_rxen", {31'd0, RxEnable}, 0);
        check_val("rst_dout", {24'd0, DataOut}, 0);

        // single byte, RxReady held 3 cycles
        p0 = pulses;
        RxData = 8'hA5; RxReady = 1'b1;
        @(negedge Clk);
        check_val("lat_valid", {31'd0, DataValid}, 1);
        check_val("lat_rxen", {31'd0, RxEnable}, 1);
        @(negedge Clk);
        check_val("rel_rxen", {31'd0, RxEnable}, 0);
        @(negedge Clk);
        RxReady = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check_val("a5_pulses", pulses - p0, 1);
        check_val("a5_count", {27'd0, Count}, 1);
        check_val("a5_dout", {24'd0, DataOut}, 32'hA5);
        check_val("a5_valid", {31'd0, DataValid}, 1);

        // fill, overflow, drain in order
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        check_val("fill_full", {31'd0, Full}, 1);
        check_val("fill_count", {27'd0, Count}, 16);
        check_val("fill_ovf", {31'd0, Overflow}, 0);
        p0 = pulses;
        send_byte(8'hFF);
        check_val("ovf_pulse", pulses - p0, 1);
        check_val("ovf_flag", {31'd0, Overflow}, 1);
        check_val("ovf_count", {27'd0, Count}, 16);
        for (int i = 0; i < 16; i++) pop_byte("drain", 8'(i));
        @(negedge Clk);
        check_val("drain_count", {27'd0, Count}, 0);
        check_val("drain_valid", {31'd0, DataValid}, 0);
        ReadEnable = 1'b1;
        @(negedge Clk);
        ReadEnable = 1'b0;
        check_val("underflow_count", {27'd0, Count}, 0);
        ClearErrors = 1'b1;
        @(negedge Clk);
        ClearErrors = 1'b0;
        check_val("ovf_clear", {31'd0, Overflow}, 0);

        // write into full FIFO with a simultaneous pop
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
        @(negedge Clk);
        check_val("sim_head", {24'd0, DataOut}, 32'h10);
        RxData = 8'h3C; RxReady = 1'b1; ReadEnable = 1'b1;
        @(negedge Clk);
        RxReady = 1'b0; ReadEnable = 1'b0;
        check_val("sim_count", {27'd0, Count}, 16);
        check_val("sim_ovf", {31'd0, Overflow}, 0);
        @(negedge Clk);
        for (int i = 1; i < 16; i++) pop_byte("sim_drain", 8'h10 + 8'(i));
        pop_byte("sim_last", 8'h3C);

        // 40 bytes interleaved, pointers wrap
        do_reset();
        model_q.delete();
        for (int i = 0; i < 40; i++) begin
            send_byte(8'(i * 3 + 7));
            model_q.push_back(8'(i * 3 + 7));
            if (i >= 3) begin
                exp_b = model_q.pop_front();
                pop_byte("wrap", exp_b);
            end
        end
        while (model_q.size() > 0) begin
            exp_b = model_q.pop_front();
            pop_byte("wrap_tail", exp_b);
        end
        @(negedge Clk);
        check_val("wrap_count", {27'd0, Count}, 0);
        check_val("wrap_valid", {31'd0, DataValid}, 0);

        // framing error: sticky, no write, no pulse; set beats clear
        send_byte(8'h11);
        send_byte(8'h22);
        p0 = pulses;
        @(negedge Clk);
        RxError = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        RxError = 1'b0;
        @(negedge Clk);
        check_val("fe_flag", {31'd0, FrameError}, 1);
        check_val("fe_count", {27'd0, Count}, 2);
        check_val("fe_pulse", pulses - p0, 0);
        ClearErrors = 1'b1;
        @(negedge Clk);
        ClearErrors = 1'b0;
        check_val("fe_clear", {31'd0, FrameError}, 0);
        RxError = 1'b1; ClearErrors = 1'b1;
        @(negedge Clk);
        RxError = 1'b0; ClearErrors = 1'b0;
        check_val("fe_set_wins", {31'd0, FrameError}, 1);

        // async reset in RELEASE with 5 entries
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'h50 + 8'(i));
        @(negedge Clk);
        RxData = 8'h54; RxReady = 1'b1;
        @(negedge Clk);
        check_val("pre_count", {27'd0, Count}, 5);
        check_val("pre_rxen", {31'd0, RxEnable}, 1);
        ClearErrors = 1'b0;
        #1 Reset = 1'b0;
        #1;
        check_val("ar_count", {27'd0, Count}, 0);
        check_val("ar_valid", {31'd0, DataValid}, 0);
        check_val("ar_full", {31'd0, Full}, 0);
        check_val("ar_rxen", {31'd0, RxEnable}, 0);
        check_val("ar_dout", {24'd0, DataOut}, 0);
        check_val("ar_ovf", {31'd0, Overflow}, 0);
        check_val("ar_fe", {31'd0, FrameError}, 0);
        @(negedge Clk);
        RxReady = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        check_val("post_count", {27'd0, Count}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of byte entries; power of two, 2..256.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), pointer width.
REQ-003 Clk  input  1  sole clock, rising-edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 RxData  input  8  received byte from the UART receiver.
REQ-006 RxReady  input  1  UART byte held and valid, level until acknowledged.
REQ-007 RxError  input  1  UART stop-bit/framing error, level.
REQ-008 RxEnable  output  1  one-cycle acknowledge to UART, releases held byte.
REQ-009 ReadEnable  input  1  consumer pop request.
REQ-010 DataOut  output  8  head-of-FIFO byte, first-word fall-through.
REQ-011 DataValid  output  1  FIFO not empty.
REQ-012 Full  output  1  Count == DEPTH.
REQ-013 Count  output  ADDR_WIDTH+1  stored entries, 0..DEPTH.
REQ-014 Overflow  output  1  sticky: byte dropped because FIFO full.
REQ-015 FrameError  output  1  sticky: RxError seen.
REQ-016 ClearErrors  input  1  synchronous clear of Overflow and FrameError.

Function
REQ-017 Capture FSM SHALL have states IDLE and RELEASE, registered.
REQ-018 IDLE: RxReady=1 at edge -> accept byte (REQ-019), RxEnable=1 next cycle, go RELEASE.
REQ-019 Accept = write RxData at write pointer if !Full or ReadEnable&&DataValid same cycle; else drop byte, set Overflow.
REQ-020 RxEnable SHALL be pulsed for dropped bytes too, so the UART always returns to idle.
REQ-021 RELEASE: RxEnable=0 from second cycle on; remain until RxReady=0, then IDLE; no second capture of same byte.
REQ-022 RxEnable SHALL be registered, high exactly one cycle per captured/dropped byte.
REQ-023 Latency RxReady rise -> DataValid=1 (empty FIFO) SHALL be 1 cycle; DataOut valid same cycle.
REQ-024 Pop: ReadEnable=1 and DataValid=1 at edge -> read pointer +1, Count -1; ReadEnable when empty ignored, no underflow.
REQ-025 Simultaneous write and pop SHALL leave Count unchanged, both pointers advance.
REQ-026 Pointers SHALL wrap modulo DEPTH; Count SHALL never exceed DEPTH nor go below 0.
REQ-027 DataOut SHALL equal the entry at read pointer whenever DataValid=1; value undefined-but-stable when empty (last read entry).
REQ-028 RxError=1 at any edge SHALL set FrameError; no FIFO write, no RxEnable pulse; FSM stays IDLE.
REQ-029 ClearErrors SHALL clear sticky flags next edge; a set event in the same cycle SHALL win.
REQ-030 Full, DataValid, Count SHALL be derived from registered state only (no combinational path from inputs).

Reset
REQ-031 Reset=0 SHALL asynchronously force: FSM IDLE, pointers 0, Count 0, DataValid 0, Full 0, RxEnable 0, Overflow 0, FrameError 0, DataOut 8'h00.
REQ-032 Reset asserted mid-RELEASE SHALL abort handshake; byte already written is discarded with FIFO contents.
REQ-033 After Reset release, first capture SHALL occur no earlier than the first rising edge with Reset=1.

Verification
REQ-034 Empty FIFO, RxData=8'hA5, RxReady held high 3 cycles -> one RxEnable pulse, Count=1, DataOut=8'hA5, DataValid=1.
REQ-035 Write 16 bytes 8'h00..8'h0F (DEPTH=16), 17th byte 8'hFF -> Full=1, Count=16, RxEnable pulsed, Overflow=1, pops return 8'h00..8'h0F in order.
REQ-036 Full FIFO, byte 8'h3C arrives with ReadEnable=1 same cycle -> Count stays 16, Overflow=0, last pop after draining yields 8'h3C.
REQ-037 Write/pop 40 bytes interleaved -> pointer wrap, order preserved, Count returns to 0, DataValid=0.
REQ-038 RxError=1 for 2 cycles -> FrameError=1, Count unchanged, no RxEnable; ClearErrors=1 one cycle -> FrameError=0.
REQ-039 Reset=0 asserted asynchronously mid-RELEASE with Count=5 -> all outputs per REQ-031 before next Clk edge.
